// File: rtl/lmdpl_pkg.sv
// Shared definitions for the LMDPL dual-rail receive path: FSM states and
// bit positions within the sticky error vector.
package lmdpl_pkg;

    typedef enum logic [1:0] {
        WAIT_PRE = 2'd0,
        PRE      = 2'd1,
        EVAL     = 2'd2
    } lmdpl_state_e;

    localparam int ERR_PRE     = 0;
    localparam int ERR_DUAL    = 1;
    localparam int ERR_TIMEOUT = 2;
    localparam int ERR_OVF     = 3;
    localparam int ERR_W       = 4;

endpackage

// File: rtl/lmdpl_rail_check.sv
// Combinational validity summary of a registered dual-rail vector.
// A pair is complete when exactly one rail is high, invalid when both are
// high, and precharged when both are low.
module lmdpl_rail_check #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] qm_r,
    input  logic [WIDTH-1:0] qmb_r,
    output logic             all_complete,
    output logic             any_both,
    output logic             all_zero
);

    logic [WIDTH-1:0] complete_v;
    logic [WIDTH-1:0] both_v;
    logic [WIDTH-1:0] zero_v;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pair
            assign complete_v[gi] = qm_r[gi] ^ qmb_r[gi];
            assign both_v[gi]     = qm_r[gi] & qmb_r[gi];
            assign zero_v[gi]     = ~(qm_r[gi] | qmb_r[gi]);
        end
    endgenerate

    assign all_complete = &complete_v;
    assign any_both     = |both_v;
    assign all_zero     = &zero_v;

endmodule

// File: rtl/lmdpl_dualrail_unmask.sv
// Receive side of an LMDPL gate datapath: registers the masked dual-rail
// outputs, tracks the precharge/evaluate phase, checks rail validity and
// hands the unmasked word to single-rail logic over valid/ready.
module lmdpl_dualrail_unmask
    import lmdpl_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             precharge,
    input  logic [WIDTH-1:0] q_m,
    input  logic [WIDTH-1:0] q_m_bar,
    input  logic [WIDTH-1:0] m_out,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ERR_W-1:0] err,
    input  logic             err_clr
);

    localparam int               CNT_W   = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);

    // Input stage: every decision is made on these registered copies.
    logic             pre_r;
    logic [WIDTH-1:0] qm_r;
    logic [WIDTH-1:0] qmb_r;
    logic [WIDTH-1:0] m_r;

    lmdpl_state_e     state_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] mask_reg;
    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic [ERR_W-1:0] err_reg;

    logic all_complete;
    logic any_both;
    logic all_zero;

    // Register the phase, both rail vectors and the mask side by side so the
    // mask latched later is the one present when precharge was sampled low.
    always_ff @(posedge clk) begin
        if (rst) begin
            pre_r <= 1'b0;
            qm_r  <= '0;
            qmb_r <= '0;
            m_r   <= '0;
        end else begin
            pre_r <= precharge;
            qm_r  <= q_m;
            qmb_r <= q_m_bar;
            m_r   <= m_out;
        end
    end

    lmdpl_rail_check #(
        .WIDTH(WIDTH)
    ) u_rail_check (
        .qm_r        (qm_r),
        .qmb_r       (qmb_r),
        .all_complete(all_complete),
        .any_both    (any_both),
        .all_zero    (all_zero)
    );

    // Phase FSM, evaluate watchdog, mask latch, result register and sticky
    // errors. Later nonblocking writes to err_reg bits override the clear so
    // that an error arriving together with err_clr is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= WAIT_PRE;
            cnt_reg       <= '0;
            mask_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            err_reg       <= '0;
        end else begin
            if (err_clr) begin
                err_reg <= '0;
            end
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end

            case (state_reg)
                WAIT_PRE: begin
                    if (pre_r) begin
                        state_reg <= PRE;
                    end
                end

                PRE: begin
                    // Rails are only required to be discharged while the
                    // phase is still precharge; the first evaluate sample may
                    // already carry data.
                    if (pre_r) begin
                        if (!all_zero) begin
                            err_reg[ERR_PRE] <= 1'b1;
                        end
                    end else begin
                        state_reg <= EVAL;
                        cnt_reg   <= '0;
                        mask_reg  <= m_r;
                    end
                end

                EVAL: begin
                    if (pre_r) begin
                        err_reg[ERR_TIMEOUT] <= 1'b1;
                        state_reg            <= PRE;
                    end else if (any_both) begin
                        err_reg[ERR_DUAL] <= 1'b1;
                        state_reg         <= WAIT_PRE;
                    end else if (all_complete) begin
                        state_reg <= WAIT_PRE;
                        // The unmasked word only ever exists in out_data_reg.
                        if (!out_valid_reg || out_ready) begin
                            out_data_reg  <= qm_r ^ mask_reg;
                            out_valid_reg <= 1'b1;
                        end else begin
                            err_reg[ERR_OVF] <= 1'b1;
                        end
                    end else if (cnt_reg == CNT_MAX) begin
                        err_reg[ERR_TIMEOUT] <= 1'b1;
                        state_reg            <= WAIT_PRE;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end

                default: begin
                    state_reg <= WAIT_PRE;
                end
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign err       = err_reg;

endmodule

// File: tb/tb_lmdpl_dualrail_unmask.sv
// Directed bench for lmdpl_dualrail_unmask (WIDTH=4, TIMEOUT=15).
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
module tb_lmdpl_dualrail_unmask;

    logic       clk;
    logic       rst;
    logic       precharge;
    logic [3:0] q_m;
    logic [3:0] q_m_bar;
    logic [3:0] m_out;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] err;
    logic       err_clr;

    int pass_cnt;
    int total_cnt;

    lmdpl_dualrail_unmask #(
        .WIDTH  (4),
        .TIMEOUT(15)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .precharge(precharge),
        .q_m      (q_m),
        .q_m_bar  (q_m_bar),
        .m_out    (m_out),
        .out_data (out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .err      (err),
        .err_clr  (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full precharge/evaluate round: rails go valid one cycle after the mask
    // is presented; out_ready is driven only on the cycle the result loads.
    task automatic do_eval(input logic [3:0] mask, input logic [3:0] qm,
                           input logic [3:0] qmb, input logic rdy);
        precharge = 1'b1; q_m = 4'b0; q_m_bar = 4'b0; m_out = 4'b0;
        tick(); tick();
        precharge = 1'b0; m_out = mask;
        tick();
        m_out = 4'b0; q_m = qm; q_m_bar = qmb;
        tick();
        out_ready = rdy;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 4'b0000) $display("FAIL reset_data: got %b want 0000", out_data);
        else pass_cnt++;
        total_cnt++;
        if (err !== 4'b0000) $display("FAIL reset_err: got %b want 0000", err);
        else pass_cnt++;
        $display("txn reset: valid=%b data=%b err=%b", out_valid, out_data, err);
    endtask

    task automatic test_basic();
        precharge = 1'b1; q_m = 4'b0; q_m_bar = 4'b0;
        tick(); tick(); tick();
        precharge = 1'b0; m_out = 4'b1010;
        tick();
        m_out = 4'b0; q_m = 4'b0110; q_m_bar = 4'b1001;
        tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL basic_latency_early: got %b want 0", out_valid);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL basic_valid: got %b want 1", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (out_data !== 4'b1100) $display("FAIL basic_data: got %b want 1100", out_data);
        else pass_cnt++;
        total_cnt++;
        if (err !== 4'b0000) $display("FAIL basic_err: got %b want 0000", err);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 4'b1100)
            $display("FAIL basic_hold: got valid=%b data=%b want 1/1100", out_valid, out_data);
        else pass_cnt++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL basic_accept: got %b want 0", out_valid);
        else pass_cnt++;
        $display("txn basic: data=1100 accepted");
    endtask

    task automatic test_overflow();
        do_eval(4'b1010, 4'b0110, 4'b1001, 1'b0);
        do_eval(4'b0000, 4'b1111, 4'b0000, 1'b0);
        total_cnt++;
        if (out_data !== 4'b1100) $display("FAIL ovf_data: got %b want 1100", out_data);
        else pass_cnt++;
        total_cnt++;
        if (err !== 4'b1000) $display("FAIL ovf_err: got %b want 1000", err);
        else pass_cnt++;
        total_cnt++;
        if (out_valid !== 1'b1) $display("FAIL ovf_valid: got %b want 1", out_valid);
        else pass_cnt++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL ovf_accept: got %b want 0", out_valid);
        else pass_cnt++;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        total_cnt++;
        if (err !== 4'b0000) $display("FAIL ovf_clear: got %b want 0000", err);
        else pass_cnt++;
        $display("txn overflow: second result dropped, err[3] raised and cleared");
    endtask

    task automatic test_back_to_back();
        do_eval(4'b1010, 4'b0110, 4'b1001, 1'b0);
        do_eval(4'b0101, 4'b0011, 4'b1100, 1'b1);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 4'b0110)
            $display("FAIL b2b_data: got valid=%b data=%b want 1/0110", out_valid, out_data);
        else pass_cnt++;
        total_cnt++;
        if (err !== 4'b0000) $display("FAIL b2b_err: got %b want 0000", err);
        else pass_cnt++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        $display("txn back_to_back: data=%b", 4'b0110);
    endtask

    task automatic test_pre_err();
        precharge = 1'b1; q_m = 4'b0; q_m_bar = 4'b0;
        tick(); tick(); tick();
        q_m = 4'b0001; tick();
        q_m = 4'b0000; tick();
        total_cnt++;
        if (err !== 4'b0001) $display("FAIL pre_err: got %b want 0001", err);
        else pass_cnt++;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        total_cnt++;
        if (err !== 4'b0000) $display("FAIL pre_err_clear: got %b want 0000", err);
        else pass_cnt++;
        $display("txn pre_err: err[0] raised and cleared");
    endtask

    task automatic test_timeout();
        precharge = 1'b1; q_m = 4'b0; q_m_bar = 4'b0;
        tick(); tick();
        precharge = 1'b0; m_out = 4'b0000;
        tick();
        q_m = 4'b0111; q_m_bar = 4'b0000;
        for (int i = 0; i < 16; i++) tick();
        total_cnt++;
        if (err !== 4'b0000) $display("FAIL timeout_early: got %b want 0000", err);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (err !== 4'b0100) $display("FAIL timeout_err: got %b want 0100", err);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL timeout_valid: got %b want 0", out_valid);
        else pass_cnt++;
        total_cnt++;
        if (dut.state_reg !== lmdpl_pkg::WAIT_PRE)
            $display("FAIL timeout_state: got %0d want 0", dut.state_reg);
        else pass_cnt++;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        do_eval(4'b0011, 4'b1001, 4'b0110, 1'b0);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 4'b1010 || err !== 4'b0000)
            $display("FAIL timeout_recover: got valid=%b data=%b err=%b want 1/1010/0000",
                     out_valid, out_data, err);
        else pass_cnt++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        // Precharge returning before completion is also a timeout.
        precharge = 1'b1; q_m = 4'b0; q_m_bar = 4'b0;
        tick(); tick();
        precharge = 1'b0; tick();
        q_m = 4'b0001; tick(); tick();
        precharge = 1'b1; q_m = 4'b0; tick(); tick();
        total_cnt++;
        if (err !== 4'b0100 || out_valid !== 1'b0)
            $display("FAIL early_pre: got err=%b valid=%b want 0100/0", err, out_valid);
        else pass_cnt++;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        $display("txn timeout: err[2] on watchdog and on early precharge");
    endtask

    task automatic test_dual();
        precharge = 1'b1; q_m = 4'b0; q_m_bar = 4'b0;
        tick(); tick();
        precharge = 1'b0; m_out = 4'b0000;
        tick();
        q_m = 4'b0100; q_m_bar = 4'b0100;
        tick(); tick();
        total_cnt++;
        if (err !== 4'b0010) $display("FAIL dual_err: got %b want 0010", err);
        else pass_cnt++;
        tick(); tick();
        total_cnt++;
        if (out_valid !== 1'b0) $display("FAIL dual_valid: got %b want 0", out_valid);
        else pass_cnt++;
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        $display("txn dual: err[1] raised, no output");
    endtask

    task automatic test_rst_mid();
        do_eval(4'b1010, 4'b0110, 4'b1001, 1'b0);
        precharge = 1'b1; q_m = 4'b0; q_m_bar = 4'b0;
        tick(); tick();
        precharge = 1'b0; tick();
        q_m = 4'b0001; tick(); tick();
        rst = 1'b1; tick(); rst = 1'b0;
        total_cnt++;
        if (out_valid !== 1'b0 || out_data !== 4'b0000 || err !== 4'b0000)
            $display("FAIL rst_mid: got valid=%b data=%b err=%b want 0/0000/0000",
                     out_valid, out_data, err);
        else pass_cnt++;
        do_eval(4'b1111, 4'b0000, 4'b1111, 1'b0);
        total_cnt++;
        if (out_valid !== 1'b1 || out_data !== 4'b1111)
            $display("FAIL rst_recover: got valid=%b data=%b want 1/1111", out_valid, out_data);
        else pass_cnt++;
        $display("txn rst_mid: pending result discarded, then data=1111");
    endtask

    initial begin
        pass_cnt = 0; total_cnt = 0;
        rst = 1'b1; precharge = 1'b0; q_m = 4'b0; q_m_bar = 4'b0;
        m_out = 4'b0; out_ready = 1'b0; err_clr = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_back_to_back();
        test_pre_err();
        test_timeout();
        test_dual();
        test_rst_mid();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
